// File: rtl/msrv_32_lsu_pkg.sv
// msrv_32 load/store unit shared definitions.
// funct3 codes, FSM encoding, timeout default and lane helpers.
package msrv_32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } lsu_state_t;

    function automatic logic lsu_ok(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic ok;
        ok = 1'b0;
        if (ld ^ st) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = !a[0];
                F3_W:    ok = (a == 2'b00);
                F3_BU:   ok = ld;
                F3_HU:   ok = ld && !a[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [31:0] st_data(
        input logic [2:0]  f3,
        input logic [31:0] rs2
    );
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{rs2[7:0]}};
            F3_H:    d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] st_mask(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << a;
            F3_H:    m = 4'b0011 << {a[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/msrv_32_load_store_unit_load_align.sv
// msrv_32 load data aligner.
// Picks the addressed byte/halfword and sign- or zero-extends it.
import msrv_32_lsu_pkg::*;

module msrv_32_load_align (
    input  logic [31:0] rd_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rd_data[{addr, 3'b000} +: 8];
        h = addr[1] ? rd_data[31:16] : rd_data[15:0];
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_BU:   data = {24'd0, b};
            F3_HU:   data = {16'd0, h};
            default: data = rd_data;
        endcase
    end

endmodule

// File: rtl/msrv_32_load_store_unit.sv
// msrv_32 data-memory load/store unit.
// One req/ack bus transaction per accepted request, with fault/timeout.
import msrv_32_lsu_pkg::*;

module msrv_32_load_store_unit #(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        ld_req_in,
    input  logic        st_req_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic [2:0]  funct3_in,
    output logic        ready_out,
    output logic [31:0] dmem_addr_out,
    output logic        dmem_rd_req_out,
    output logic        dmem_wr_req_out,
    output logic [31:0] dmem_wr_data_out,
    output logic [3:0]  dmem_wr_mask_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rd_data_in,
    output logic [31:0] load_data_out,
    output logic        done_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ld_q, ld_d;
    logic [1:0]  a_q, a_d;
    logic [2:0]  f3_q, f3_d;
    logic        ready_d, rd_d, wr_d, done_d, mis_d, err_d;
    logic [31:0] addr_d, wdata_d, ldata_d, aligned;
    logic [3:0]  mask_d;

    msrv_32_load_align u_align (
        .rd_data (dmem_rd_data_in),
        .addr    (a_q),
        .funct3  (f3_q),
        .data    (aligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        a_d     = a_q;
        f3_d    = f3_q;
        ready_d = ready_out;
        addr_d  = dmem_addr_out;
        rd_d    = dmem_rd_req_out;
        wr_d    = dmem_wr_req_out;
        wdata_d = dmem_wr_data_out;
        mask_d  = dmem_wr_mask_out;
        ldata_d = load_data_out;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_req_in || st_req_in) begin
                    ready_d = 1'b0;
                    if (lsu_ok(ld_req_in, st_req_in, funct3_in, iadder_in[1:0])) begin
                        state_d = ACCESS;
                        cnt_d   = 8'd0;
                        ld_d    = ld_req_in;
                        a_d     = iadder_in[1:0];
                        f3_d    = funct3_in;
                        addr_d  = {iadder_in[31:2], 2'b00};
                        rd_d    = ld_req_in;
                        wr_d    = st_req_in;
                        wdata_d = st_data(funct3_in, rs2_in);
                        mask_d  = st_req_in ? st_mask(funct3_in, iadder_in[1:0]) : 4'b0000;
                    end else begin
                        state_d = FAULT;
                        mis_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // ack beats a timeout landing in the same cycle
                if (dmem_ack_in) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = 1'b1;
                    if (ld_q) ldata_d = aligned;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= IDLE;
            cnt_q            <= 8'd0;
            ld_q             <= 1'b0;
            a_q              <= 2'b00;
            f3_q             <= 3'b000;
            ready_out        <= 1'b1;
            dmem_addr_out    <= 32'd0;
            dmem_rd_req_out  <= 1'b0;
            dmem_wr_req_out  <= 1'b0;
            dmem_wr_data_out <= 32'd0;
            dmem_wr_mask_out <= 4'd0;
            load_data_out    <= 32'd0;
            done_out         <= 1'b0;
            misaligned_out   <= 1'b0;
            bus_err_out      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ld_q             <= ld_d;
            a_q              <= a_d;
            f3_q             <= f3_d;
            ready_out        <= ready_d;
            dmem_addr_out    <= addr_d;
            dmem_rd_req_out  <= rd_d;
            dmem_wr_req_out  <= wr_d;
            dmem_wr_data_out <= wdata_d;
            dmem_wr_mask_out <= mask_d;
            load_data_out    <= ldata_d;
            done_out         <= done_d;
            misaligned_out   <= mis_d;
            bus_err_out      <= err_d;
        end
    end

endmodule

// File: tb/tb_msrv_32_load_store_unit.sv
// Scoreboard bench for msrv_32_load_store_unit.
// Driver pushes expected bus/response items; a monitor pops and compares.
module tb_msrv_32_load_store_unit;

    localparam int TO = 4;
    localparam int K_DONE = 0;
    localparam int K_MIS = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cycles;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        wr;
    } bus_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        ld_req_in = 1'b0;
    logic        st_req_in = 1'b0;
    logic [31:0] iadder_in = '0;
    logic [31:0] rs2_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        ready_out;
    logic [31:0] dmem_addr_out;
    logic        dmem_rd_req_out;
    logic        dmem_wr_req_out;
    logic [31:0] dmem_wr_data_out;
    logic [3:0]  dmem_wr_mask_out;
    logic        dmem_ack_in = 1'b0;
    logic [31:0] dmem_rd_data_in = '0;
    logic [31:0] load_data_out;
    logic        done_out;
    logic        misaligned_out;
    logic        bus_err_out;

    int checks = 0;
    int failures = 0;
    resp_t exp_q[$];
    bus_t  bus_q[$];
    logic [31:0] model_load = '0;

    msrv_32_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .ld_req_in        (ld_req_in),
        .st_req_in        (st_req_in),
        .iadder_in        (iadder_in),
        .rs2_in           (rs2_in),
        .funct3_in        (funct3_in),
        .ready_out        (ready_out),
        .dmem_addr_out    (dmem_addr_out),
        .dmem_rd_req_out  (dmem_rd_req_out),
        .dmem_wr_req_out  (dmem_wr_req_out),
        .dmem_wr_data_out (dmem_wr_data_out),
        .dmem_wr_mask_out (dmem_wr_mask_out),
        .dmem_ack_in      (dmem_ack_in),
        .dmem_rd_data_in  (dmem_rd_data_in),
        .load_data_out    (load_data_out),
        .done_out         (done_out),
        .misaligned_out   (misaligned_out),
        .bus_err_out      (bus_err_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endfunction

    // Reference model: legality from the access-size/alignment rules
    function automatic bit m_legal(bit ld, bit st, logic [2:0] f3, logic [1:0] a);
        int size;
        if (ld == st) return 0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
        logic [31:0] v;
        if (f3 == 3'd2) return w;
        if (f3[1:0] == 2'd0) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = (w >> (16 * (a / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    // Monitor: bus stability/content and output event scoreboard
    bit    in_req = 0;
    int    req_cnt = 0;
    bus_t  cur;
    resp_t r;
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            in_req = 0;
        end else begin
            if ((dmem_rd_req_out || dmem_wr_req_out) && !in_req) begin
                in_req = 1;
                req_cnt = 0;
                checks++;
                if (bus_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_bus_req addr=%h", dmem_addr_out);
                    cur = '{addr: dmem_addr_out, data: dmem_wr_data_out,
                            mask: dmem_wr_mask_out, wr: dmem_wr_req_out};
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            if (dmem_rd_req_out || dmem_wr_req_out) begin
                req_cnt++;
                chk("bus_addr", dmem_addr_out, cur.addr);
                chk("bus_wr_req", 32'(dmem_wr_req_out), 32'(cur.wr));
                chk("bus_rd_req", 32'(dmem_rd_req_out), 32'(!cur.wr));
                if (cur.wr) begin
                    chk("bus_wr_data", dmem_wr_data_out, cur.data);
                    chk("bus_wr_mask", 32'(dmem_wr_mask_out), 32'(cur.mask));
                end
            end else begin
                in_req = 0;
            end
            if (done_out || misaligned_out || bus_err_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event done=%0b mis=%0b err=%0b",
                             done_out, misaligned_out, bus_err_out);
                end else begin
                    r = exp_q.pop_front();
                    chk("event_kind", {29'd0, bus_err_out, misaligned_out, done_out},
                        32'(1 << r.kind));
                    chk("event_ready", 32'(ready_out), 32'(r.kind != K_MIS));
                    chk("load_data", load_data_out, r.data);
                    if (r.kind != K_MIS) chk("req_cycles", req_cnt, r.cycles);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int d);
        int w;
        bit ok;
        int n;
        logic [31:0] wd;
        logic [3:0]  wm;
        w = 0;
        while (!ready_out && w < 50) begin
            step();
            w++;
        end
        chk("ready_wait", 32'(ready_out), 32'd1);
        ld_req_in = ld;
        st_req_in = st;
        funct3_in = f3;
        iadder_in = addr;
        rs2_in = rs2;
        ok = m_legal(ld, st, f3, addr[1:0]);
        if (ok) begin
            wd = rs2;
            wm = 4'hF;
            if (f3[1:0] == 2'd0) begin
                wd = rs2[7:0] * 32'h0101_0101;
                wm = 4'(1 << addr[1:0]);
            end else if (f3[1:0] == 2'd1) begin
                wd = rs2[15:0] * 32'h0001_0001;
                wm = 4'(3 << (addr[1:0] & 2'd2));
            end
            bus_q.push_back('{addr: addr & ~32'd3, data: wd, mask: wm, wr: st});
            if (d < TO) begin
                if (ld) model_load = m_load(f3, addr[1:0], rdata);
                exp_q.push_back('{kind: K_DONE, data: model_load, cycles: d + 1});
            end else begin
                exp_q.push_back('{kind: K_ERR, data: model_load, cycles: TO});
            end
        end else begin
            exp_q.push_back('{kind: K_MIS, data: model_load, cycles: 0});
        end
        step();
        // One cycle of input noise while the unit is busy
        ld_req_in = 1'($urandom);
        st_req_in = 1'($urandom);
        funct3_in = 3'($urandom);
        iadder_in = $urandom;
        rs2_in = $urandom;
        if (!ok) begin
            dmem_ack_in = 1'($urandom);
            step();
            ld_req_in = 0;
            st_req_in = 0;
            dmem_ack_in = 0;
        end else begin
            n = (d < TO) ? d + 1 : TO;
            for (int c = 0; c < n; c++) begin
                dmem_ack_in = (c == d);
                dmem_rd_data_in = (c == d) ? rdata : $urandom;
                step();
                ld_req_in = 0;
                st_req_in = 0;
            end
            dmem_ack_in = 0;
            dmem_rd_data_in = $urandom;
        end
    endtask

    initial begin
        bit ld, st;
        int sel, d;
        logic [2:0] f3;
        logic [2:0] legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_rd_req", 32'(dmem_rd_req_out), 32'd0);
        chk("rst_wr_req", 32'(dmem_wr_req_out), 32'd0);
        chk("rst_addr", dmem_addr_out, 32'd0);
        chk("rst_load_data", load_data_out, 32'd0);
        chk("rst_pulses", {29'd0, done_out, misaligned_out, bus_err_out}, 32'd0);
        rst_n_in = 1'b1;
        step();

        // LW dropped by reset mid-ACCESS; late ack is ignored
        ld_req_in = 1;
        funct3_in = 3'd2;
        iadder_in = 32'h0000_1000;
        bus_q.push_back('{addr: 32'h1000, data: 32'h0, mask: 4'h0, wr: 1'b0});
        step();
        ld_req_in = 0;
        step();
        step();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_rd_req", 32'(dmem_rd_req_out), 32'd0);
        chk("arst_addr", dmem_addr_out, 32'd0);
        chk("arst_ready", 32'(ready_out), 32'd1);
        chk("arst_done", 32'(done_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step();
        dmem_ack_in = 1;
        dmem_rd_data_in = 32'hDEAD_BEEF;
        step();
        dmem_ack_in = 0;
        chk("late_ack_done", 32'(done_out), 32'd0);
        chk("late_ack_load", load_data_out, 32'd0);
        step();
        chk("late_ack_done2", 32'(done_out), 32'd0);

        access(1, 0, 3'd0, 32'h103, 0, 32'h80AA_BBCC, 1);
        chk("lb_sext", load_data_out, 32'hFFFF_FF80);
        access(1, 0, 3'd4, 32'h103, 0, 32'h80AA_BBCC, 2);
        chk("lbu_zext", load_data_out, 32'h0000_0080);
        access(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 0, 1);
        access(1, 0, 3'd2, 32'h301, 0, 0, 0);
        access(1, 0, 3'd1, 32'h305, 0, 0, 0);
        access(0, 1, 3'd3, 32'h400, 32'h1, 0, 0);
        access(1, 1, 3'd2, 32'h400, 32'h1, 0, 0);
        access(1, 0, 3'd2, 32'h500, 0, 32'h1111_2222, 99);
        access(1, 0, 3'd5, 32'h502, 0, 32'h8001_7FFF, 3);
        access(1, 0, 3'd2, 32'h600, 0, 32'hCAFE_F00D, 0);
        chk("zw_ready", 32'(ready_out), 32'd1);
        access(0, 1, 3'd0, 32'h601, 32'h55, 0, 0);
        access(1, 0, 3'd1, 32'h602, 0, 32'h8765_4321, 0);
        chk("lh_sext", load_data_out, 32'hFFFF_8765);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 19);
            ld = (sel < 11) || (sel == 19);
            st = (sel >= 11);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            d = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, TO - 1);
            access(ld, st, f3, $urandom, $urandom, $urandom, d);
        end

        repeat (4) step();
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msrv_32_load_store_unit.md
# msrv_32_load_store_unit

Data-memory access unit for the msrv_32 core. It takes the effective address produced by the immediate adder (rs1 + imm), plus store data and funct3, and runs one load or store transaction on the data-memory bus using a req/ack handshake. Loads return sign- or zero-extended data; stores produce byte-lane masks. Misaligned, illegal and timed-out accesses are flagged to the trap logic.

## Interface
- TIMEOUT_CYCLES, 255: number of ACCESS cycles without `dmem_ack_in` before a bus error is raised; range 1–255.
- clk_in  input  1  core clock; all state changes on the rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- ld_req_in  input  1  load request, sampled only while ready_out=1
- st_req_in  input  1  store request, sampled only while ready_out=1
- iadder_in  input  32  effective byte address
- rs2_in  input  32  store source data
- funct3_in  input  3  access size/sign, RV32I encoding
- ready_out  output  1  unit is idle and can accept a request
- dmem_addr_out  output  32  word address, {iadder[31:2],2'b00}
- dmem_rd_req_out  output  1  read request
- dmem_wr_req_out  output  1  write request
- dmem_wr_data_out  output  32  lane-replicated store data
- dmem_wr_mask_out  output  4  byte-lane write enables
- dmem_ack_in  input  1  memory completes the current request
- dmem_rd_data_in  input  32  read data, valid with ack
- load_data_out  output  32  aligned, extended load result; holds its value until the next load completes
- done_out  output  1  one-cycle pulse when an access completes
- misaligned_out  output  1  one-cycle pulse for a misaligned or illegal request
- bus_err_out  output  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, ACCESS, FAULT.
- In IDLE, ready_out=1.
- Accept rule: in IDLE, if exactly one of ld_req_in/st_req_in is 1, capture the request.
  - Legal and aligned: register the bus outputs, go to ACCESS.
  - Otherwise: go to FAULT and make no bus access.
- Fault conditions:
  - ld_req_in and st_req_in both asserted.
  - Load funct3 not one of 000, 001, 010, 100, 101.
  - Store funct3 not one of 000, 001, 010.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- FAULT: pulse misaligned_out, return to IDLE.
- ACCESS: hold the bus outputs stable until dmem_ack_in=1. On ack:
  - Deassert the request.
  - Pulse done_out.
  - For a load, update load_data_out.
  - Return to IDLE.
- Timeout counter (8 bits) clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop the request, pulse bus_err_out and return to IDLE.
  - If ack arrives in the same cycle the limit is reached, ack wins: done_out, no bus_err_out.
- Store lane rules:
  - SB: data = {4{rs2[7:0]}}, mask = 4'b0001 << addr[1:0].
  - SH: data = {2{rs2[15:0]}}, mask = 4'b0011 << {addr[1],1'b0}.
  - SW: data = rs2, mask = 4'b1111.
- Load rules: byte selected by addr[1:0], halfword by addr[1].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Load address and funct3 are captured at accept; later changes on the inputs have no effect.
- dmem_ack_in in IDLE or FAULT is ignored.

## Timing
- Reset values: all outputs 0 except ready_out=1; FSM in IDLE; timeout counter 0.
- Assertion of rst_n_in clears the state immediately, including mid-ACCESS; the pending transaction is dropped with no done_out.
- Request accepted at edge N: dmem_*_req_out high from N+1.
- Ack sampled at edge M≥N+1: done_out and load_data_out valid during cycle M+1, ready_out=1 in M+1.
- Minimum accept-to-accept interval: 2 cycles. Minimum latency: 2 cycles.
- Fault accepted at N: misaligned_out high during N+1, ready_out=1 again at N+2.
- ready_out=0 in ACCESS and FAULT; requests presented then are not sampled.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package msrv_32_lsu_pkg holds:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - FSM state encoding.
  - The default timeout value.
- Sub-module msrv_32_load_align: purely combinational; (rd_data, addr[1:0], funct3) → extended 32-bit result. It is instantiated once and feeds the load_data_out register.

## Test plan
- Reset mid-ACCESS:
  - LW at 0x0000_1000, ack held low 3 cycles, then rst_n_in=0 → all outputs return to reset values asynchronously.
  - A late ack after reset is released → ignored, no done_out.
- LB sign/zero extension:
  - LB at 0x103, rd_data 0x80AA_BBCC → load_data_out 0xFFFF_FF80.
  - LBU at the same address and data → 0x0000_0080.
- SH at 0x202 with rs2 0x1234_ABCD → addr 0x200, data 0xABCD_ABCD, mask 4'b1100, one done_out after ack.
- Misaligned and illegal requests, each with no bus request and one misaligned_out pulse:
  - LW at 0x301.
  - LH at 0x305.
  - Store with funct3 011.
  - ld_req_in and st_req_in both high.
- Timeout, TIMEOUT_CYCLES=4, ack never asserted → request held exactly 4 cycles, then bus_err_out pulse, then ready_out=1.
- Zero-wait memory, back-to-back requests:
  - Ack returned the first cycle the request is visible → done_out 2 cycles after accept.
  - A second request at the next ready cycle → accepted.
  - Inputs changed during ACCESS → ignored.
